// File: rtl/id_ex_stage_register_pkg.sv
// Shared pipeline definitions: control-word bit positions, forward-select encodings
// and default datapath widths used by the ID/EX stage.
package id_ex_stage_register_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_AW = 5;
  localparam int DEFAULT_CTRL_W = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/id_ex_stage_register_forward_select.sv
// Execute-stage operand forwarding select for one source operand.
// MEM result beats WB result; x0 and bubbles never forward.
module forward_select
  import id_ex_stage_register_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic [REG_AW-1:0] RsE,
  input  logic              ValidE,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  output fwd_sel_t          Forward
);

  always_comb begin
    Forward = FWD_RF;
    // A zero RsE makes both destination matches imply Rd==0, so one test covers x0.
    if (ValidE && (RsE != '0)) begin
      if (RegWriteM && (RdM == RsE)) begin
        Forward = FWD_MEM;
      end else if (RegWriteW && (RdW == RsE)) begin
        Forward = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with stall/flush control and the execute-stage
// forwarding selects derived from the registered source specifiers.
module id_ex_stage_register
  import id_ex_stage_register_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_AW = DEFAULT_REG_AW,
  parameter int CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ImmExtD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [DATA_W-1:0] PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  // Flush outranks stall so a load-use hold cannot keep a squashed instruction alive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else if (FlushE) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else if (!StallE) begin
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      CtrlE    <= CtrlD;
      ValidE   <= 1'b1;
    end
  end

  forward_select #(.REG_AW(REG_AW)) u_fwd_a (
    .RsE       (Rs1E),
    .ValidE    (ValidE),
    .RegWriteM (RegWriteM),
    .RdM       (RdM),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .Forward   (ForwardAE)
  );

  forward_select #(.REG_AW(REG_AW)) u_fwd_b (
    .RsE       (Rs2E),
    .ValidE    (ValidE),
    .RegWriteM (RegWriteM),
    .RdM       (RdM),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .Forward   (ForwardBE)
  );

endmodule

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

ID/EX pipeline register of the pipelined core, with the forwarding-select generator for the execute stage. Each cycle it captures decode-stage operands, immediate, PC+4, register specifiers and control word. It also supports stall (hold) and flush (bubble insertion). From the registered source specifiers and the MEM/WB destination info it drives ForwardAE/ForwardBE, which select between register-file data, WB result and MEM ALU result in the execute-stage operand muxes.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-specifier width
- CTRL_W, 8, control word width; bit 0 = RegWrite, bit 1 = MemWrite, others pass through

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- StallE  input  1  hold all E-stage contents
- FlushE  input  1  load a bubble next edge
- RD1D, RD2D  input  DATA_W  register-file read data
- ImmExtD, PCPlus4D  input  DATA_W  extended immediate, PC+4
- Rs1D, Rs2D, RdD  input  REG_AW  source/destination specifiers
- CtrlD  input  CTRL_W  decoded control word
- RegWriteM  input  1  MEM-stage write enable
- RdM  input  REG_AW  MEM-stage destination
- RegWriteW  input  1  WB-stage write enable
- RdW  input  REG_AW  WB-stage destination
- RD1E, RD2E, ImmExtE, PCPlus4E  output  DATA_W  registered copies
- Rs1E, Rs2E, RdE  output  REG_AW  registered specifiers
- CtrlE  output  CTRL_W  registered control word
- ValidE  output  1  E stage holds a real instruction
- ForwardAE, ForwardBE  output  2  operand A/B select: 00 register file, 01 WB result, 10 MEM ALU result

## Operation
- Update priority at each rising edge: reset > FlushE > StallE > normal load.
- Normal load: every E register takes its D input; ValidE <= 1.
- StallE=1, FlushE=0: all registers keep their value, including ValidE.
- FlushE=1 (any StallE): bubble. All data and specifier registers go to 0, CtrlE to 0 (RegWrite=0, MemWrite=0), ValidE <= 0.
- Reset: every registered output 0, ValidE 0. Effect is immediate on assertion, without waiting for a clock edge.
- Forwarding is combinational from the registered Rs1E/Rs2E and the live M/W inputs. The same rule applies to ForwardBE with Rs2E:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E
  - else 00
- MEM match has priority over WB match, so the younger result wins.
- Register 0 is never forwarded.
- Select 11 is never produced.
- With ValidE=0 both selects are forced to 00.

## Timing
- Latency: D inputs appear on E outputs one clock after a non-stalled, non-flushed edge.
- Forward selects respond combinationally, in the same cycle, to changes in RegWriteM/RdM/RegWriteW/RdW and to E-register updates. No extra cycle.
- Reset values: all outputs 0, including ForwardAE/BE = 00.
- Reset deasserted mid-stream: the first edge with rst_n=1 performs a normal load, subject to StallE/FlushE.
- Simultaneous StallE and FlushE: flush wins. This is used for load-use plus branch-taken.
- Stall held N cycles: outputs unchanged for N cycles. Forward selects may still change as M/W advance.

## Structure
- A shared pipeline package holds:
  - the control-word bit positions (CTRL_REGWRITE=0, CTRL_MEMWRITE=1)
  - the forward-select encodings (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10)
  - default widths
- One sub-module: forward_select. It is purely combinational and instantiated twice (A and B). Inputs: RsE, ValidE, RegWriteM, RdM, RegWriteW, RdW.
- The pipeline register itself is a single clocked process inside id_ex_stage_register.

## Test plan
- Reset: assert rst_n=0 with nonzero D inputs. Required response: all outputs 0 and ForwardAE/BE=00 immediately. Then release reset, present RD1D=0x11111111, Rs1D=3. Required response: after one edge RD1E=0x11111111, Rs1E=3, ValidE=1.
- Stall: load RD1D=0xA, then apply StallE=1 for 3 cycles while changing RD1D=0xB. Required response: RD1E stays 0xA for all 3 cycles, then becomes 0xB one edge after StallE drops.
- Flush priority: StallE=1 and FlushE=1 with CtrlD=0xFF. Required response: after the edge CtrlE=0, RdE=0, ValidE=0, ForwardAE=00.
- MEM vs WB priority: Rs1E=5, RegWriteM=1, RdM=5, RegWriteW=1, RdW=5. Required response: ForwardAE=10. Then drop RegWriteM. Required response: ForwardAE=01 in the same cycle.
- x0 guard: Rs2E=0, RegWriteM=1, RdM=0. Required response: ForwardBE=00. Also Rs2E=7 with RegWriteW=0 and RdW=7. Required response: ForwardBE=00.
